// File: rtl/xlr_dmy2_pkg.sv
// xlr_dmy2_pkg: shared types, host register indices and status layout for xbox_xlr_dmy2.
package xlr_dmy2_pkg;
   typedef enum logic [1:0] {OP_COPY, OP_ADD, OP_XOR, OP_RSVD} xlr_op_e;
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RD, S_WAIT, S_WR, S_DONE} state_e;
   localparam int REG_MODE = 0;
   localparam int REG_BANKS = 1;
   localparam int REG_ADDR = 2;
   localparam int REG_LEN = 3;
   localparam int ST_WORD = 0;
   localparam int ST_LINES = 1;
   localparam int ST_CSUM = 2;
   localparam int ST_DONE_BIT = 0;
   localparam int ST_ERR_BIT = 1;
   localparam int ST_DROP_BIT = 2;
   function automatic logic [31:0] status_word(input logic drop, input logic err);
      status_word = '0;
      status_word[ST_DONE_BIT] = 1'b1;
      status_word[ST_ERR_BIT] = err;
      status_word[ST_DROP_BIT] = drop;
   endfunction
endpackage

// File: rtl/xlr_dmy2_alu.sv
// xlr_dmy2_alu: combinational 32-bit lane-wise COPY/ADD/XOR over a memory line.
module xlr_dmy2_alu
   import xlr_dmy2_pkg::*;
#(
   parameter int LINE_W = 256
) (
   input  xlr_op_e             op,
   input  logic [LINE_W-1:0]   a,
   input  logic [LINE_W-1:0]   b,
   output logic [LINE_W-1:0]   y
);
   // each lane sum is truncated to 32 bits so no carry crosses a lane boundary
   for (genvar i = 0; i < LINE_W / 32; i++) begin : g_lane
      assign y[i*32 +: 32] = op == OP_ADD ? a[i*32 +: 32] + b[i*32 +: 32] :
                             op == OP_XOR ? a[i*32 +: 32] ^ b[i*32 +: 32] : a[i*32 +: 32];
   end
endmodule

// File: rtl/xbox_xlr_dmy2.sv
// xbox_xlr_dmy2: host-kicked line streamer, reads one or two banks, lane ALU, writes a bank.
// Define XLR_CHECKSUM_EN to report a running XOR of all written lanes in status register 2.
module xbox_xlr_dmy2
   import xlr_dmy2_pkg::*;
#(
   parameter int NUM_MEMS = 4,
   parameter int LOG2_LINES_PER_MEM = 8,
   parameter int LINE_W = 256,
   parameter int NUM_REGS = 8
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
   output logic [NUM_MEMS-1:0][LINE_W-1:0]              xlr_mem_wdata,
   output logic [NUM_MEMS-1:0][LINE_W/8-1:0]            xlr_mem_be,
   output logic [NUM_MEMS-1:0]                          xlr_mem_rd,
   output logic [NUM_MEMS-1:0]                          xlr_mem_wr,
   input  logic [NUM_MEMS-1:0][LINE_W-1:0]              xlr_mem_rdata,
   input  logic [NUM_REGS-1:0][31:0]                    host_regs,
   input  logic                                         host_regs_valid_pulse,
   output logic [NUM_REGS-1:0][31:0]                    host_regs_data_out,
   output logic                                         host_regs_valid_out
);
   localparam int AW = LOG2_LINES_PER_MEM;
   localparam int BW = $clog2(NUM_MEMS);
   localparam logic [3:0] NB = 4'(NUM_MEMS);
   localparam logic [32:0] LIM = 33'(1) << AW;

   state_e state;
   xlr_op_e op;
   logic [3:0] src_a, src_b, dst;
   logic [31:0] start, len, rem, written, csum_nxt;
   logic [AW-1:0] cur, rd_addr;
   logic drop, bad, unused_ok;
   logic [NUM_MEMS-1:0] rd_mask, wr_mask;
   logic [LINE_W-1:0] alu_y;

   assign unused_ok = ^host_regs;
   // range check is one bit wider than the operands so start+len cannot wrap
   assign bad = op == OP_RSVD || src_a >= NB || src_b >= NB || dst >= NB || len == '0 ||
                {1'b0, start} + {1'b0, len} > LIM;
   assign rd_addr = state == S_CHECK ? start[AW-1:0] : cur + AW'(1);

   always_comb begin
      rd_mask = '0;
      wr_mask = '0;
      rd_mask[src_a[BW-1:0]] = 1'b1;
      rd_mask[src_b[BW-1:0]] = rd_mask[src_b[BW-1:0]] | (op != OP_COPY);
      wr_mask[dst[BW-1:0]] = 1'b1;
   end

   xlr_dmy2_alu #(.LINE_W(LINE_W)) u_alu (
      .op (op),
      .a  (xlr_mem_rdata[src_a[BW-1:0]]),
      .b  (xlr_mem_rdata[src_b[BW-1:0]]),
      .y  (alu_y)
   );

`ifdef XLR_CHECKSUM_EN
   logic [31:0] csum;
   function automatic logic [31:0] fold(input logic [LINE_W-1:0] d);
      fold = '0;
      for (int i = 0; i < LINE_W / 32; i++) fold ^= d[i*32 +: 32];
   endfunction
   assign csum_nxt = csum ^ fold(xlr_mem_wdata[dst[BW-1:0]]);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) csum <= '0;
      else if (state == S_IDLE && host_regs_valid_pulse) csum <= '0;
      else if (state == S_WR) csum <= csum_nxt;
`else
   assign csum_nxt = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         op <= OP_COPY;
         src_a <= '0;
         src_b <= '0;
         dst <= '0;
         start <= '0;
         len <= '0;
         rem <= '0;
         written <= '0;
         cur <= '0;
         drop <= 1'b0;
         xlr_mem_addr <= '0;
         xlr_mem_wdata <= '0;
         xlr_mem_be <= '0;
         xlr_mem_rd <= '0;
         xlr_mem_wr <= '0;
         host_regs_data_out <= '0;
         host_regs_valid_out <= 1'b0;
      end else begin
         host_regs_valid_out <= 1'b0;
         if (host_regs_valid_pulse && state != S_IDLE) drop <= 1'b1;
         case (state)
            S_IDLE: if (host_regs_valid_pulse) begin
               op <= xlr_op_e'(host_regs[REG_MODE][1:0]);
               src_a <= host_regs[REG_BANKS][3:0];
               src_b <= host_regs[REG_BANKS][7:4];
               dst <= host_regs[REG_BANKS][11:8];
               start <= host_regs[REG_ADDR];
               len <= host_regs[REG_LEN];
               written <= '0;
               drop <= 1'b0;
               host_regs_data_out <= '0;
               state <= S_CHECK;
            end
            S_CHECK: if (bad) begin
               state <= S_DONE;
               host_regs_valid_out <= 1'b1;
               host_regs_data_out[ST_WORD] <= status_word(drop || host_regs_valid_pulse, 1'b1);
            end else begin
               state <= S_RD;
               cur <= rd_addr;
               rem <= len;
               xlr_mem_rd <= rd_mask;
               for (int i = 0; i < NUM_MEMS; i++) xlr_mem_addr[i] <= rd_addr & {AW{rd_mask[i]}};
            end
            S_RD: begin
               state <= S_WAIT;
               xlr_mem_rd <= '0;
               xlr_mem_addr <= '0;
            end
            S_WAIT: begin
               state <= S_WR;
               xlr_mem_wr <= wr_mask;
               for (int i = 0; i < NUM_MEMS; i++) begin
                  xlr_mem_addr[i] <= cur & {AW{wr_mask[i]}};
                  xlr_mem_wdata[i] <= alu_y & {LINE_W{wr_mask[i]}};
                  xlr_mem_be[i] <= {(LINE_W/8){wr_mask[i]}};
               end
            end
            S_WR: begin
               xlr_mem_wr <= '0;
               xlr_mem_wdata <= '0;
               xlr_mem_be <= '0;
               written <= written + 32'd1;
               if (rem > 32'd1) begin
                  rem <= rem - 32'd1;
                  cur <= rd_addr;
                  state <= S_RD;
                  xlr_mem_rd <= rd_mask;
                  for (int i = 0; i < NUM_MEMS; i++) xlr_mem_addr[i] <= rd_addr & {AW{rd_mask[i]}};
               end else begin
                  state <= S_DONE;
                  xlr_mem_addr <= '0;
                  host_regs_valid_out <= 1'b1;
                  host_regs_data_out[ST_WORD] <= status_word(drop || host_regs_valid_pulse, 1'b0);
                  host_regs_data_out[ST_LINES] <= written + 32'd1;
                  host_regs_data_out[ST_CSUM] <= csum_nxt;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xbox_xlr_dmy2.sv
// tb_xbox_xlr_dmy2: directed commands against a bench memory and a line-level reference model.
module tb_xbox_xlr_dmy2;
   localparam int NM = 4;
   localparam int AW = 8;
   localparam int LW = 256;
   localparam int NR = 8;
   localparam int NL = LW / 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NM-1:0][AW-1:0] mem_addr;
   logic [NM-1:0][LW-1:0] mem_wdata;
   logic [NM-1:0][LW/8-1:0] mem_be;
   logic [NM-1:0] mem_rd, mem_wr;
   logic [NM-1:0][LW-1:0] mem_rdata;
   logic [NR-1:0][31:0] host_regs;
   logic pulse;
   logic [NR-1:0][31:0] data_out;
   logic valid_out;

   always #5 clk = ~clk;

   xbox_xlr_dmy2 #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(AW), .LINE_W(LW), .NUM_REGS(NR)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .xlr_mem_addr          (mem_addr),
      .xlr_mem_wdata         (mem_wdata),
      .xlr_mem_be            (mem_be),
      .xlr_mem_rd            (mem_rd),
      .xlr_mem_wr            (mem_wr),
      .xlr_mem_rdata         (mem_rdata),
      .host_regs             (host_regs),
      .host_regs_valid_pulse (pulse),
      .host_regs_data_out    (data_out),
      .host_regs_valid_out   (valid_out)
   );

   typedef struct { logic [NM-1:0] mask; logic [AW-1:0] addr; } rd_t;
   typedef struct { logic [NM-1:0] mask; logic [AW-1:0] addr; logic [LW-1:0] data; } wr_t;

   logic [LW-1:0] mem [NM][256];
   logic [LW-1:0] mm [NM][256];
   rd_t rdq [$];
   wr_t wrq [$];
   rd_t re;
   wr_t we;
   logic [31:0] exp_st [NR];
   logic exp_valid = 1'b0;
   logic holding = 1'b1;
   logic zb;
   int nvec = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
      nvec++;
      if (got !== want) begin
         nfail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   function automatic logic [LW-1:0] lanes(input logic [31:0] v);
      for (int k = 0; k < NL; k++) lanes[k*32 +: 32] = v;
   endfunction

   function automatic logic [31:0] fold(input logic [LW-1:0] d);
      fold = '0;
      for (int k = 0; k < NL; k++) fold ^= d[k*32 +: 32];
   endfunction

   function automatic logic [LW-1:0] pat(input int b, input int l);
      for (int k = 0; k < NL; k++) pat[k*32 +: 32] = {8'(b + 1), 8'(l), 8'(k), 8'hC3};
   endfunction

   function automatic logic [LW-1:0] init_val(input int b, input int l);
      init_val = pat(b, l);
      if (b == 0 && l >= 16 && l < 20) init_val = LW'(l - 15);
      if (b == 0 && (l == 32 || l == 33)) init_val = lanes(32'hFFFF_FFFF);
      if (b == 2 && (l == 32 || l == 33)) init_val = lanes(32'h0000_0002);
      if (b == 0 && l == 128) init_val = LW'(32'hA5A5_A5A5);
      if (b == 0 && l == 129) init_val = {LW'(32'h5A5A_5A5A)} << 96;
   endfunction

   // bench-side memory banks: one-cycle read latency, full-line writes
   always @(posedge clk)
      for (int i = 0; i < NM; i++) begin
         if (mem_rd[i]) mem_rdata[i] <= mem[i][mem_addr[i]];
         if (mem_wr[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
      end

   always @(negedge clk) begin
      zb = 1'b0;
      for (int i = 0; i < NM; i++) begin
         if (!mem_rd[i] && !mem_wr[i] && mem_addr[i] != '0) zb = 1'b1;
         if (!mem_wr[i] && (mem_wdata[i] != '0 || mem_be[i] != '0)) zb = 1'b1;
      end
      chk("quiet_bank_zero", zb, 1'b0);
      if (|mem_rd) begin
         if (rdq.size() == 0) chk("unexpected_rd", mem_rd, '0);
         else begin
            re = rdq.pop_front();
            chk("rd_mask", mem_rd, re.mask);
            for (int i = 0; i < NM; i++) if (re.mask[i]) chk("rd_addr", mem_addr[i], re.addr);
         end
      end
      if (|mem_wr) begin
         if (wrq.size() == 0) chk("unexpected_wr", mem_wr, '0);
         else begin
            we = wrq.pop_front();
            chk("wr_mask", mem_wr, we.mask);
            for (int i = 0; i < NM; i++) if (we.mask[i]) begin
               chk("wr_addr", mem_addr[i], we.addr);
               chk("wr_data", mem_wdata[i], we.data);
               chk("wr_be", mem_be[i], {(LW/8){1'b1}});
            end
         end
      end
      if (valid_out) begin
         chk("valid_expected", valid_out, exp_valid);
         for (int r = 0; r < NR; r++) chk("status_reg", data_out[r], exp_st[r]);
         exp_valid = 1'b0;
         holding = 1'b1;
      end else if (holding)
         for (int r = 0; r < NR; r++) chk("held_status", data_out[r], exp_st[r]);
   end

   task automatic run_cmd(input int mode, input int a, input int b, input int d, input int addr,
                          input int len, input int inj, input int rst_at, input logic exp_drop);
      logic err;
      logic [31:0] csum, x, y;
      logic [LW-1:0] av, bv, r;
      logic [NM-1:0] m;
      logic [LW-1:0] old [256];
      int lat;
      logic seen;
      err = mode == 3 || a >= NM || b >= NM || d >= NM || len == 0 || addr + len > 256;
      csum = '0;
      if (d < NM) for (int l = 0; l < 256; l++) old[l] = mm[d][l];
      if (!err)
         for (int j = 0; j < len; j++) begin
            av = mm[a][addr + j];
            bv = mm[b][addr + j];
            for (int k = 0; k < NL; k++) begin
               x = av[k*32 +: 32];
               y = bv[k*32 +: 32];
               r[k*32 +: 32] = mode == 1 ? x + y : mode == 2 ? x ^ y : x;
            end
            m = '0;
            m[a] = 1'b1;
            if (mode != 0) m[b] = 1'b1;
            rdq.push_back('{m, AW'(addr + j)});
            m = '0;
            m[d] = 1'b1;
            wrq.push_back('{m, AW'(addr + j), r});
            mm[d][addr + j] = r;
            csum ^= fold(r);
         end
      for (int q = 0; q < NR; q++) exp_st[q] = '0;
      exp_st[0] = {29'd0, exp_drop, err, 1'b1};
      exp_st[1] = err ? 32'd0 : 32'(len);
`ifdef XLR_CHECKSUM_EN
      exp_st[2] = csum;
`endif
      host_regs[0] = 32'(mode);
      host_regs[1] = {20'd0, 4'(d), 4'(b), 4'(a)};
      host_regs[2] = 32'(addr);
      host_regs[3] = 32'(len);
      exp_valid = 1'b1;
      holding = 1'b0;
      pulse = 1'b1;
      @(posedge clk);
      #1 pulse = 1'b0;
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 3 * len + 12) begin
         @(posedge clk);
         lat++;
         #1 pulse = (lat == inj);
         if (lat == rst_at) begin
            rst_n = 1'b0;
            #1 chk("async_reset_outputs",
                   |{mem_addr, mem_wdata, mem_be, mem_rd, mem_wr, data_out, valid_out}, 1'b0);
            rdq.delete();
            wrq.delete();
            exp_valid = 1'b0;
            for (int j = (rst_at - 1) / 3; j < len; j++) mm[d][addr + j] = old[addr + j];
            for (int q = 0; q < NR; q++) exp_st[q] = '0;
            holding = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
         seen = valid_out;
      end
      chk("done_seen", seen, 1'b1);
      if (seen) chk("latency", lat, err ? 1 : 1 + 3 * len);
      @(posedge clk);
      #1 chk("rd_left", rdq.size(), 0);
      chk("wr_left", wrq.size(), 0);
      chk("status_consumed", exp_valid, 1'b0);
   endtask

   initial begin
      host_regs = '0;
      pulse = 1'b0;
      for (int q = 0; q < NR; q++) exp_st[q] = '0;
      for (int b = 0; b < NM; b++)
         for (int l = 0; l < 256; l++) begin
            mem[b][l] <= init_val(b, l);
            mm[b][l] = init_val(b, l);
         end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("reset_valid_out", valid_out, 1'b0);
      chk("reset_status0", data_out[0], 32'd0);
      run_cmd(0, 0, 0, 1, 16, 4, 0, 0, 1'b0);
      for (int i = 0; i < 4; i++) chk("copy_line", mem[1][16 + i], LW'(i + 1));
      chk("copy_status0", data_out[0], 32'h1);
      chk("copy_lines", data_out[1], 32'd4);
      run_cmd(1, 0, 2, 3, 32, 2, 0, 0, 1'b0);
      chk("add_line0", mem[3][32], lanes(32'h1));
      chk("add_line1", mem[3][33], lanes(32'h1));
      run_cmd(2, 1, 2, 1, 48, 3, 0, 0, 1'b0);
      run_cmd(0, 2, 0, 0, 254, 2, 0, 0, 1'b0);
      chk("edge_line_fe", mem[0][254], pat(2, 254));
      chk("edge_line_ff", mem[0][255], pat(2, 255));
      run_cmd(0, 2, 0, 0, 255, 2, 0, 0, 1'b0);
      chk("range_err_status", data_out[0], 32'h3);
      run_cmd(0, 0, 0, 4, 0, 1, 0, 0, 1'b0);
      run_cmd(3, 0, 1, 2, 0, 1, 0, 0, 1'b0);
      run_cmd(0, 0, 0, 1, 0, 0, 0, 0, 1'b0);
      run_cmd(0, 3, 0, 2, 64, 3, 3, 0, 1'b1);
      chk("drop_status", data_out[0], 32'h5);
      run_cmd(2, 3, 3, 0, 80, 1, 0, 0, 1'b0);
      chk("drop_cleared", data_out[0], 32'h1);
      run_cmd(1, 1, 3, 2, 96, 5, 0, 6, 1'b0);
      run_cmd(0, 2, 0, 3, 96, 5, 0, 0, 1'b0);
      run_cmd(0, 0, 0, 3, 128, 2, 0, 0, 1'b0);
`ifdef XLR_CHECKSUM_EN
      chk("checksum", data_out[2], 32'hFFFF_FFFF);
`else
      chk("checksum_off", data_out[2], 32'h0);
`endif
      zb = 1'b0;
      for (int b = 0; b < NM; b++)
         for (int l = 0; l < 256; l++) if (mem[b][l] !== mm[b][l]) zb = 1'b1;
      chk("mem_image", zb, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
